// File: rtl/vend_controller.sv
// vend_controller: coin credit accumulator, vend authorisation and greedy change dispenser.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_controller #(
  parameter int PRICE = 65,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_nickel,
  input  logic       coin_dime,
  input  logic       coin_quarter,
  input  logic       vend_req,
  input  logic       cancel_req,
  input  logic       disp_ready,
  output logic [6:0] credit,
  output logic       vend,
  output logic       vend_deny,
  output logic       coin_reject,
  output logic       disp_valid,
  output logic [1:0] disp_coin,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [6:0] credit_n, coin_val, paid, left;
  logic [7:0] sum;
  logic vend_n, deny_n, reject_n, any_coin, multi_coin, timeout;
  function automatic logic [1:0] pick(input logic [6:0] v);
    return v >= 7'd25 ? 2'b11 : v >= 7'd10 ? 2'b10 : 2'b01;
  endfunction
  assign any_coin = coin_nickel | coin_dime | coin_quarter;
  assign multi_coin = (coin_nickel & coin_dime) | (coin_nickel & coin_quarter) | (coin_dime & coin_quarter);
  assign coin_val = coin_quarter ? 7'd25 : coin_dime ? 7'd10 : 7'd5;
  assign sum = {1'b0, credit} + {1'b0, coin_val};
  assign paid = disp_coin == 2'b11 ? 7'd25 : disp_coin == 2'b10 ? 7'd10 : 7'd5;
  // credit doubles as the remaining-change register outside IDLE
  assign left = credit - paid;
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic activity;
  assign activity = any_coin | vend_req | cancel_req;
  assign timeout = state == IDLE && idle_cnt == TW'(TIMEOUT_CYCLES) && !activity;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (state == IDLE && credit != 7'd0 && !activity && !timeout) ? idle_cnt + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    credit_n = credit;
    vend_n = 1'b0;
    deny_n = 1'b0;
    reject_n = any_coin & (state != IDLE | multi_coin | vend_req | cancel_req | sum > 8'd127);
    case (state)
      IDLE:
        if (cancel_req | timeout) state_n = credit != 7'd0 ? CHANGE : IDLE;
        else if (vend_req) begin
          if (credit >= 7'(PRICE)) begin
            state_n = VEND;
            credit_n = credit - 7'(PRICE);
            vend_n = 1'b1;
          end else deny_n = 1'b1;
        end else if (any_coin & !reject_n) credit_n = sum[6:0];
      VEND: state_n = credit == 7'd0 ? IDLE : CHANGE;
      CHANGE:
        if (disp_ready) begin
          credit_n = left;
          state_n = left == 7'd0 ? IDLE : CHANGE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      credit <= '0;
      vend <= 1'b0;
      vend_deny <= 1'b0;
      coin_reject <= 1'b0;
      disp_valid <= 1'b0;
      disp_coin <= 2'b00;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      vend <= vend_n;
      vend_deny <= deny_n;
      coin_reject <= reject_n;
      disp_valid <= state_n == CHANGE;
      disp_coin <= state_n == CHANGE ? pick(credit_n) : 2'b00;
      busy <= state_n != IDLE;
    end
endmodule
